// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite definitions used by the data-port initiator and
//            the slave decode/glue: transfer-type encoding, size/response/
//            protection constants, the ROM region tag and the write-data
//            lane replication helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic       HRESP_OKAY  = 1'b0;
   localparam logic       HRESP_ERROR = 1'b1;

   // Privileged, non-bufferable, non-cacheable; bit 0 selects data vs opcode
   localparam logic [3:0] HPROT_DATA  = 4'b0011;
   localparam logic [3:0] HPROT_FETCH = 4'b0010;

   // Upper address byte that selects the ROM region in the slave decode
   localparam logic [7:0] ROM_BASE    = 8'hA0;

   // Copies an LSB-justified store value onto every byte lane it could occupy,
   // so the slave can pick its lanes from the address without a shifter here.
   function automatic logic [31:0] lane_replicate(input logic [31:0] wdata,
                                                  input logic [2:0]  size);
      case (size)
         HSIZE_BYTE: return {4{wdata[7:0]}};
         HSIZE_HALF: return {2{wdata[15:0]}};
         default:    return wdata;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_data_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_data_master
// Purpose  : AHB-Lite initiator for the core data port. Accepts load/store
//            requests on a valid/ready handshake, runs a two-stage
//            (address phase / data phase) pipeline onto the bus, absorbs wait
//            states and two-cycle ERROR responses, and returns exactly one
//            response per accepted request.
// Ports    :
//   hclk, hresetn              clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_addr/write/size/wdata  request payload (store data LSB-justified)
//   req_fetch                  opcode fetch, clears hprot[0]
//   rsp_valid/rsp_err/rdata    one-cycle response pulse
//   haddr..hwdata              AHB-Lite master outputs
//   hrdata/hready/hresp        AHB-Lite slave returns
// Revision : 1.0  initial release
// ============================================================================
module ahb_data_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              hclk,
   input  logic              hresetn,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [2:0]        req_size,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_fetch,

   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,

   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [3:0]        hprot,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      ERR2 = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Address-phase stage
   logic                r_aph_valid;
   logic [ADDR_W-1:0]   r_aph_addr;
   logic                r_aph_write;
   logic [2:0]          r_aph_size;
   logic                r_aph_fetch;
   logic [DATA_W-1:0]   r_aph_wdata;

   // Data-phase stage
   logic                r_dph_valid;
   logic                r_dph_write;
   logic [DATA_W-1:0]   r_hwdata;

   // Response register
   logic                r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;

   logic                w_req_ready;
   logic                w_accept;
   logic                w_aph_done;
   logic                w_dph_done;
   htrans_t             w_htrans;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and pipeline control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_aph_done  = 1'b0;
      w_htrans    = IDLE;
      // The data phase retires on any hready, including the second cycle of
      // a two-cycle error.
      w_dph_done  = r_dph_valid && hready;
      case (r_state)
         RUN: begin
            // A queued address phase only frees its slot when the bus is
            // moving and no error is in flight on the data phase.
            w_req_ready = !r_aph_valid || (hready && (hresp == HRESP_OKAY));
            w_aph_done  = r_aph_valid && hready;
            if (r_aph_valid) begin
               w_htrans = NONSEQ;
            end
            if (r_dph_valid && (hresp == HRESP_ERROR) && !hready) begin
               w_state_nxt = ERR2;
            end
         end
         ERR2: begin
            // Bus shows IDLE here, so the held address phase is not sampled
            // and must be re-issued once back in RUN.
            if (hready) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   assign w_accept = req_valid && w_req_ready;

   // ------------------------------------------------------------------------
   // Address-phase stage
   // ------------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_aph_valid <= 1'b0;
         r_aph_addr  <= '0;
         r_aph_write <= 1'b0;
         r_aph_size  <= HSIZE_WORD;
         r_aph_fetch <= 1'b0;
         r_aph_wdata <= '0;
      end else if (w_accept) begin
         r_aph_valid <= 1'b1;
         r_aph_addr  <= req_addr;
         r_aph_write <= req_write;
         r_aph_size  <= req_size;
         r_aph_fetch <= req_fetch;
         r_aph_wdata <= req_wdata;
      end else if (w_aph_done) begin
         // Payload is left in place so the bus outputs stay quiet and stable.
         r_aph_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Data-phase stage
   // ------------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_dph_valid <= 1'b0;
         r_dph_write <= 1'b0;
         r_hwdata    <= '0;
      end else if (w_aph_done) begin
         r_dph_valid <= 1'b1;
         r_dph_write <= r_aph_write;
         r_hwdata    <= lane_replicate(r_aph_wdata, r_aph_size);
      end else if (w_dph_done) begin
         r_dph_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Response
   // ------------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (w_dph_done) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= (hresp == HRESP_ERROR);
         r_rsp_rdata <= r_dph_write ? '0 : hrdata;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign req_ready = w_req_ready;
   assign htrans    = w_htrans;
   assign haddr     = r_aph_addr;
   assign hwrite    = r_aph_write;
   assign hsize     = r_aph_size;
   assign hprot     = r_aph_fetch ? HPROT_FETCH : HPROT_DATA;
   assign hwdata    = r_hwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_data_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_data_master
// Purpose  : Directed self-checking bench for ahb_data_master. The main
//            sequence plays the slave cycle by cycle and checks bus outputs;
//            expected responses are queued as requests are issued and a
//            monitor pops and compares them as rsp_valid pulses appear.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_data_master;

   logic        hclk;
   logic        hresetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        req_fetch;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_vec;
   int   n_err;

   ahb_data_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .req_fetch (req_fetch),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hprot     (hprot),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Move just past the next rising edge; inputs are changed here.
   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   // Mid-cycle sampling point for outputs.
   task automatic mid();
      @(negedge hclk);
   endtask

   task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic fetch);
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_size  = size;
      req_wdata = wdata;
      req_fetch = fetch;
   endtask

   task automatic push_exp(input logic err, input logic [31:0] rdata);
      exp_t e;
      e.err   = err;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Response monitor / scoreboard
   always @(negedge hclk) begin
      if (hresetn && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      hresetn   = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_size  = 3'd2;
      req_wdata = '0;
      req_fetch = 1'b0;
      hrdata    = '0;
      hready    = 1'b1;
      hresp     = 1'b0;

      // ---------------- reset values ----------------
      repeat (2) cyc();
      mid();
      chk("rst_htrans", {30'd0, htrans}, 32'd0);
      chk("rst_haddr", haddr, 32'd0);
      chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
      chk("rst_hsize", {29'd0, hsize}, 32'd2);
      chk("rst_hprot", {28'd0, hprot}, 32'h3);
      chk("rst_hwdata", hwdata, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      cyc();
      hresetn = 1'b1;
      mid();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // ---------------- word read, no waits ----------------
      cyc();
      drive_req(32'h0000_0010, 1'b0, 3'd2, 32'd0, 1'b0);
      push_exp(1'b0, 32'hDEAD_BEEF);
      mid();
      chk("rd_ready", {31'd0, req_ready}, 32'd1);
      chk("rd_idle_before", {30'd0, htrans}, 32'd0);
      cyc();                                   // accept edge T
      req_valid = 1'b0;
      mid();
      chk("rd_nonseq_t1", {30'd0, htrans}, 32'h2);
      chk("rd_haddr", haddr, 32'h0000_0010);
      chk("rd_hwrite", {31'd0, hwrite}, 32'd0);
      chk("rd_hsize", {29'd0, hsize}, 32'd2);
      chk("rd_hprot", {28'd0, hprot}, 32'h3);
      cyc();                                   // T+1 -> data phase
      hrdata = 32'hDEAD_BEEF;
      mid();
      chk("rd_idle_t2", {30'd0, htrans}, 32'd0);
      chk("rd_no_rsp_t2", {31'd0, rsp_valid}, 32'd0);
      cyc();
      hrdata = 32'd0;
      mid();
      chk("rd_rsp_t3", {31'd0, rsp_valid}, 32'd1);

      // ---------------- byte store ----------------
      cyc();
      drive_req(32'h0000_0003, 1'b1, 3'd0, 32'h0000_005A, 1'b0);
      push_exp(1'b0, 32'd0);
      mid();
      cyc();
      req_valid = 1'b0;
      mid();
      chk("bs_nonseq", {30'd0, htrans}, 32'h2);
      chk("bs_hsize", {29'd0, hsize}, 32'd0);
      chk("bs_hwrite", {31'd0, hwrite}, 32'd1);
      chk("bs_haddr", haddr, 32'h0000_0003);
      cyc();
      mid();
      chk("bs_hwdata", hwdata, 32'h5A5A_5A5A);
      cyc();
      mid();
      chk("bs_rsp", {31'd0, rsp_valid}, 32'd1);

      // ---------------- three back-to-back writes, 2 waits on the 2nd ----------------
      cyc();
      drive_req(32'h0000_0100, 1'b1, 3'd2, 32'h1111_1111, 1'b0);
      push_exp(1'b0, 32'd0);
      mid();
      cyc();
      drive_req(32'h0000_0104, 1'b1, 3'd2, 32'h2222_2222, 1'b0);
      push_exp(1'b0, 32'd0);
      mid();
      chk("b2b_w0_haddr", haddr, 32'h0000_0100);
      chk("b2b_ready1", {31'd0, req_ready}, 32'd1);
      cyc();
      drive_req(32'h0000_0108, 1'b1, 3'd2, 32'h3333_3333, 1'b0);
      push_exp(1'b0, 32'd0);
      mid();
      chk("b2b_w1_haddr", haddr, 32'h0000_0104);
      chk("b2b_w0_hwdata", hwdata, 32'h1111_1111);
      chk("b2b_ready2", {31'd0, req_ready}, 32'd1);
      cyc();
      req_valid = 1'b0;
      hready    = 1'b0;
      mid();
      chk("b2b_w0_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_wait1_haddr", haddr, 32'h0000_0108);
      chk("b2b_wait1_htrans", {30'd0, htrans}, 32'h2);
      chk("b2b_wait1_hwdata", hwdata, 32'h2222_2222);
      chk("b2b_wait1_ready", {31'd0, req_ready}, 32'd0);
      cyc();
      mid();
      chk("b2b_wait2_haddr", haddr, 32'h0000_0108);
      chk("b2b_wait2_hwdata", hwdata, 32'h2222_2222);
      chk("b2b_wait2_ready", {31'd0, req_ready}, 32'd0);
      chk("b2b_wait2_norsp", {31'd0, rsp_valid}, 32'd0);
      cyc();
      hready = 1'b1;
      mid();
      chk("b2b_ready_after", {31'd0, req_ready}, 32'd1);
      chk("b2b_norsp_after", {31'd0, rsp_valid}, 32'd0);
      cyc();
      mid();
      chk("b2b_w1_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_w2_hwdata", hwdata, 32'h3333_3333);
      chk("b2b_idle", {30'd0, htrans}, 32'd0);
      cyc();
      mid();
      chk("b2b_w2_rsp", {31'd0, rsp_valid}, 32'd1);

      // ---------------- single-cycle error on ROM write, queued read ----------------
      cyc();
      drive_req(32'hA000_0000, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b0);
      push_exp(1'b1, 32'd0);
      mid();
      cyc();
      drive_req(32'h0000_0020, 1'b0, 3'd2, 32'd0, 1'b0);
      push_exp(1'b0, 32'h1234_5678);
      mid();
      chk("e1_haddr", haddr, 32'hA000_0000);
      cyc();
      req_valid = 1'b0;
      hresp     = 1'b1;
      mid();
      chk("e1_rd_haddr", haddr, 32'h0000_0020);
      chk("e1_rd_nonseq", {30'd0, htrans}, 32'h2);
      chk("e1_ready", {31'd0, req_ready}, 32'd0);
      cyc();
      hresp  = 1'b0;
      hrdata = 32'h1234_5678;
      mid();
      chk("e1_wr_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("e1_idle", {30'd0, htrans}, 32'd0);
      cyc();
      hrdata = 32'd0;
      mid();
      chk("e1_rd_rsp", {31'd0, rsp_valid}, 32'd1);

      // ---------------- two-cycle error on read, queued write ----------------
      cyc();
      drive_req(32'h0000_0030, 1'b0, 3'd2, 32'd0, 1'b0);
      push_exp(1'b1, 32'd0);
      mid();
      cyc();
      drive_req(32'h0000_0034, 1'b1, 3'd2, 32'h0BAD_F00D, 1'b0);
      push_exp(1'b0, 32'd0);
      mid();
      chk("e2_rd_haddr", haddr, 32'h0000_0030);
      cyc();
      req_valid = 1'b0;
      hresp     = 1'b1;
      hready    = 1'b0;
      mid();
      chk("e2_c1_nonseq", {30'd0, htrans}, 32'h2);
      chk("e2_c1_haddr", haddr, 32'h0000_0034);
      chk("e2_c1_ready", {31'd0, req_ready}, 32'd0);
      cyc();
      hready = 1'b1;
      mid();
      chk("e2_c2_idle", {30'd0, htrans}, 32'd0);
      chk("e2_c2_ready", {31'd0, req_ready}, 32'd0);
      chk("e2_c2_norsp", {31'd0, rsp_valid}, 32'd0);
      cyc();
      hresp = 1'b0;
      mid();
      chk("e2_rd_rsp", {31'd0, rsp_valid}, 32'd1);
      chk("e2_reissue_nonseq", {30'd0, htrans}, 32'h2);
      chk("e2_reissue_haddr", haddr, 32'h0000_0034);
      chk("e2_reissue_hwrite", {31'd0, hwrite}, 32'd1);
      cyc();
      mid();
      chk("e2_wr_hwdata", hwdata, 32'h0BAD_F00D);
      chk("e2_wr_idle", {30'd0, htrans}, 32'd0);
      cyc();
      mid();
      chk("e2_wr_rsp", {31'd0, rsp_valid}, 32'd1);

      // ---------------- fetch read of ROM ----------------
      cyc();
      drive_req(32'hA000_0100, 1'b0, 3'd2, 32'd0, 1'b1);
      push_exp(1'b0, 32'h1357_9BDF);
      mid();
      cyc();
      req_valid = 1'b0;
      req_fetch = 1'b0;
      mid();
      chk("fe_hprot", {28'd0, hprot}, 32'h2);
      chk("fe_nonseq", {30'd0, htrans}, 32'h2);
      cyc();
      hrdata = 32'h1357_9BDF;
      mid();
      cyc();
      hrdata = 32'd0;
      mid();
      chk("fe_rsp", {31'd0, rsp_valid}, 32'd1);

      // ---------------- reset during data phase ----------------
      cyc();
      drive_req(32'h0000_0040, 1'b1, 3'd2, 32'h7777_7777, 1'b0);
      mid();
      cyc();
      req_valid = 1'b0;
      mid();
      chk("rs_nonseq", {30'd0, htrans}, 32'h2);
      cyc();
      hready = 1'b0;
      mid();
      chk("rs_hwdata_pre", hwdata, 32'h7777_7777);
      #1;
      hresetn = 1'b0;
      #1;
      chk("rs_htrans", {30'd0, htrans}, 32'd0);
      chk("rs_haddr", haddr, 32'd0);
      chk("rs_hwrite", {31'd0, hwrite}, 32'd0);
      chk("rs_hsize", {29'd0, hsize}, 32'd2);
      chk("rs_hprot", {28'd0, hprot}, 32'h3);
      chk("rs_hwdata", hwdata, 32'd0);
      chk("rs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      cyc();
      hresetn = 1'b1;
      hready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("rs_no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("rs_idle", {30'd0, htrans}, 32'd0);
         cyc();
      end

      chk("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
